// File: rtl/minterm_scanner_pkg.sv
// Shared types and helpers for the minterm scanner.
//   state_e        : scan FSM states
//   KIND_*         : term-kind encodings carried on term_kind
//   tt_width()     : truth-table width for a given variable count
package minterm_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic KIND_MAXTERM = 1'b0;
    localparam logic KIND_MINTERM = 1'b1;

    // Number of input combinations of an n-variable function.
    function automatic int unsigned tt_width(input int unsigned n_vars);
        return 32'd1 << n_vars;
    endfunction

endpackage

// File: rtl/term_evaluator.sv
// Combinational evaluation of one truth-table index against both canonical forms.
//   sop_mask_i : bit i = 1 -> index i is a minterm
//   pos_mask_i : bit i = 1 -> index i is a maxterm
//   index_i    : input combination being evaluated
//   f_sop_o    : function value from the sum-of-products mask
//   f_pos_o    : function value from the product-of-sums mask
//   disagree_o : the two forms differ at this index
module term_evaluator
    import minterm_scanner_pkg::*;
#(
    parameter int unsigned N_VARS = 4,
    parameter int unsigned TT_W   = tt_width(N_VARS)
) (
    input  logic [TT_W-1:0]   sop_mask_i,
    input  logic [TT_W-1:0]   pos_mask_i,
    input  logic [N_VARS-1:0] index_i,
    output logic              f_sop_o,
    output logic              f_pos_o,
    output logic              disagree_o
);

    always_comb begin
        f_sop_o    = sop_mask_i[index_i];
        f_pos_o    = ~pos_mask_i[index_i];
        disagree_o = f_sop_o ^ f_pos_o;
    end

endmodule

// File: rtl/minterm_scanner.sv
// Sequential truth-table scanner: latches SOP/POS masks on start, streams one
// term record per index over valid/ready and counts the minterms accepted.
// Optional SOP/POS equivalence check is compiled in with
// MINTERM_SCANNER_EQUIV_CHECK_EN.
//   clk, rst_n         : clock, async active-low reset
//   start              : begin a scan (IDLE only)
//   sop_mask, pos_mask : minterm / maxterm masks, latched on start
//   busy, done         : scan in progress / one-cycle completion pulse
//   term_valid/ready   : record handshake
//   term_index/kind    : offered index and its kind (1 = minterm)
//   ones_count         : minterms accepted in current or last scan
//   mismatch(_index)   : sticky form disagreement and its first index
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int unsigned N_VARS = 4,
    parameter int unsigned TT_W   = tt_width(N_VARS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TT_W-1:0]   sop_mask,
    input  logic [TT_W-1:0]   pos_mask,
    output logic              busy,
    output logic              done,
    output logic              term_valid,
    input  logic              term_ready,
    output logic [N_VARS-1:0] term_index,
    output logic              term_kind,
    output logic [N_VARS:0]   ones_count,
    output logic              mismatch,
    output logic [N_VARS-1:0] mismatch_index
);

    localparam int unsigned      CNT_W    = N_VARS + 1;
    localparam logic [N_VARS-1:0] LAST_IDX = N_VARS'(TT_W - 1);

    state_e              state_q, state_d;
    logic [N_VARS-1:0]   idx_q, idx_d;
    logic [TT_W-1:0]     sop_q, sop_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                kind_q, kind_d;
    logic [TT_W-1:0]     pos_cur, pos_nxt;
    logic                accept;

    logic                f_sop_cur, f_pos_cur, disagree_cur;
    logic                f_sop_nxt, f_pos_nxt, disagree_nxt;
    logic                unused_sink;

`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
    logic [TT_W-1:0]     pos_q, pos_d;
    logic                mm_q, mm_d;
    logic [N_VARS-1:0]   mmi_q, mmi_d;

    assign pos_cur     = pos_q;
    assign pos_nxt     = pos_d;
    assign unused_sink = ^{f_pos_cur, f_pos_nxt, disagree_nxt};
`else
    assign pos_cur     = '0;
    assign pos_nxt     = '0;
    assign unused_sink = ^{pos_mask, f_pos_cur, disagree_cur, f_pos_nxt, disagree_nxt};
`endif

    // Current index: drives counting and the equivalence check.
    term_evaluator #(.N_VARS(N_VARS), .TT_W(TT_W)) u_eval_cur (
        .sop_mask_i (sop_q),
        .pos_mask_i (pos_cur),
        .index_i    (idx_q),
        .f_sop_o    (f_sop_cur),
        .f_pos_o    (f_pos_cur),
        .disagree_o (disagree_cur)
    );

    // Next index: pre-computes the kind so term_kind comes straight from a flop.
    term_evaluator #(.N_VARS(N_VARS), .TT_W(TT_W)) u_eval_nxt (
        .sop_mask_i (sop_d),
        .pos_mask_i (pos_nxt),
        .index_i    (idx_d),
        .f_sop_o    (f_sop_nxt),
        .f_pos_o    (f_pos_nxt),
        .disagree_o (disagree_nxt)
    );

    assign accept = valid_q & term_ready;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sop_d   = sop_q;
        ones_d  = ones_q;
`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
        pos_d   = pos_q;
        mm_d    = mm_q;
        mmi_d   = mmi_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    sop_d   = sop_mask;
                    ones_d  = '0;
`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
                    pos_d   = pos_mask;
                    mm_d    = 1'b0;
                    mmi_d   = '0;
`endif
                end
            end
            SCAN: begin
                if (accept) begin
                    // Wrap to 0 on the last index coincides with leaving SCAN.
                    idx_d = idx_q + N_VARS'(1);
                    if (f_sop_cur == KIND_MINTERM) begin
                        ones_d = ones_q + CNT_W'(1);
                    end
`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
                    if (disagree_cur && !mm_q) begin
                        mm_d  = 1'b1;
                        mmi_d = idx_q;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == SCAN);
        done_d  = (state_d == DONE);
    end

    assign kind_d = (state_d == SCAN) ? f_sop_nxt : KIND_MAXTERM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sop_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            kind_q  <= KIND_MAXTERM;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sop_q   <= sop_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
        end
    end

`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
    // Latched POS mask and sticky first-disagreement capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            mm_q  <= 1'b0;
            mmi_q <= '0;
        end else begin
            pos_q <= pos_d;
            mm_q  <= mm_d;
            mmi_q <= mmi_d;
        end
    end

    assign mismatch       = mm_q;
    assign mismatch_index = mmi_q;
`else
    assign mismatch       = 1'b0;
    assign mismatch_index = '0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign term_valid = valid_q;
    assign term_index = idx_q;
    assign term_kind  = kind_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed self-checking bench for minterm_scanner with N_VARS = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_minterm_scanner;

`ifdef MINTERM_SCANNER_EQUIV_CHECK_EN
    localparam bit EQ_ON = 1'b1;
`else
    localparam bit EQ_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] sop_mask;
    logic [15:0] pos_mask;
    logic        busy;
    logic        done;
    logic        term_valid;
    logic        term_ready;
    logic [3:0]  term_index;
    logic        term_kind;
    logic [4:0]  ones_count;
    logic        mismatch;
    logic [3:0]  mismatch_index;

    int n_cmp = 0;
    int n_bad = 0;

    minterm_scanner #(.N_VARS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sop_mask       (sop_mask),
        .pos_mask       (pos_mask),
        .busy           (busy),
        .done           (done),
        .term_valid     (term_valid),
        .term_ready     (term_ready),
        .term_index     (term_index),
        .term_kind      (term_kind),
        .ones_count     (ones_count),
        .mismatch       (mismatch),
        .mismatch_index (mismatch_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".busy"},  32'(busy), 0);
        check({name, ".done"},  32'(done), 0);
        check({name, ".valid"}, 32'(term_valid), 0);
        check({name, ".kind"},  32'(term_kind), 0);
        check({name, ".index"}, 32'(term_index), 0);
        check({name, ".ones"},  32'(ones_count), 0);
        check({name, ".mm"},    32'(mismatch), 0);
        check({name, ".mmi"},   32'(mismatch_index), 0);
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at the falling
    // edge of the first IDLE cycle after DONE, ready for a back-to-back start.
    task automatic scan(input string name, input logic [15:0] sop, input logic [15:0] pos,
                        input bit toggle, input bit disturb, input int exp_ones,
                        input bit exp_mm, input int exp_mmi, input int exp_done);
        int cyc;
        int idx;
        bit seen_done;
        bit r;
        start      = 1'b1;
        sop_mask   = sop;
        pos_mask   = pos;
        term_ready = 1'b1;
        cyc        = 0;
        idx        = 0;
        seen_done  = 1'b0;
        while (!seen_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                check({name, ".done_cycle"}, 32'(cyc), 32'(exp_done));
                check({name, ".valid_at_done"}, 32'(term_valid), 0);
                check({name, ".handshakes"}, 32'(idx), 16);
                check({name, ".ones"}, 32'(ones_count), 32'(exp_ones));
                check({name, ".mm"}, 32'(mismatch), 32'(exp_mm & EQ_ON));
                check({name, ".mmi"}, 32'(mismatch_index), EQ_ON ? 32'(exp_mmi) : 0);
            end else if (idx >= 16) begin
                seen_done = 1'b1;
                check({name, ".done_after_last"}, 32'(done), 1);
            end else begin
                if (cyc == 1) check({name, ".busy_c1"}, 32'(busy), 1);
                check($sformatf("%s.valid@%0d", name, idx), 32'(term_valid), 1);
                check($sformatf("%s.index@%0d", name, idx), 32'(term_index), 32'(idx));
                check($sformatf("%s.kind@%0d", name, idx), 32'(term_kind), 32'(sop[idx]));
                r = toggle ? ((cyc % 2) == 0) : 1'b1;
                term_ready = r;
                if (disturb && idx == 5) begin
                    start    = 1'b1;
                    sop_mask = ~sop;
                    pos_mask = ~pos;
                end
                if (r) idx++;
            end
        end
        if (!seen_done) check({name, ".timeout"}, 0, 1);
        @(negedge clk);
        check({name, ".idle_busy"}, 32'(busy), 0);
        check({name, ".idle_done"}, 32'(done), 0);
        check({name, ".ones_held"}, 32'(ones_count), 32'(exp_ones));
    endtask

    initial begin
        int guard;
        rst_n      = 1'b1;
        start      = 1'b0;
        sop_mask   = '0;
        pos_mask   = '0;
        term_ready = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Agreeing forms, ready high: done in cycle 17.
        scan("agree",    16'h9527, 16'h6AD8, 1'b0, 1'b0, 8, 1'b0, 0, 17);
        // Forms differ only at index 0.
        scan("diff0",    16'h9527, 16'h6AD9, 1'b0, 1'b0, 8, 1'b1, 0, 17);
        // Differences at 4 and 10: first one is kept.
        scan("first",    16'h9527, 16'h6EC8, 1'b0, 1'b0, 8, 1'b1, 4, 17);
        // All minterms with alternating ready: done in cycle 33, count 16.
        scan("allones",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16, 1'b0, 0, 33);
        // No minterms.
        scan("allzeros", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0, 0, 17);
        // start and new masks mid-scan are ignored.
        scan("restart",  16'h9527, 16'h6AD8, 1'b0, 1'b1, 8, 1'b0, 0, 17);

        // Reset in the middle of a scan, then rescan from index 0.
        start      = 1'b1;
        sop_mask   = 16'h9527;
        pos_mask   = 16'h6AD8;
        term_ready = 1'b1;
        guard      = 0;
        @(negedge clk);
        start = 1'b0;
        while (term_index != 4'd7 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("midrst.reached_idx7", 32'(term_index), 7);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        check_reset_state("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        scan("after_rst", 16'h00F0, 16'hFF0F, 1'b0, 1'b0, 4, 1'b0, 0, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
